// File: rtl/draw_scheduler.sv
// Card-deck draw scheduler: arbitrates player draw requests, deals, discards
// and shuffles onto a single deck command bus, with a watchdog on deck replies.
module draw_scheduler #(
    parameter int N_PLAYERS  = 4,
    parameter int DEAL_COUNT = 7,
    parameter int WDOG_MAX   = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_shuffle,
    input  logic                   i_deal,
    input  logic [N_PLAYERS-1:0]   i_req,
    input  logic [3*N_PLAYERS-1:0] i_req_num,
    input  logic                   i_discard_valid,
    input  logic [5:0]             i_discard_card,
    output logic                   o_discard_ack,
    output logic [N_PLAYERS-1:0]   o_grant,
    output logic                   o_card_valid,
    output logic [5:0]             o_card,
    output logic [1:0]             o_card_player,
    output logic                   o_busy,
    output logic                   o_error,
    output logic                   o_deck_start,
    output logic                   o_deck_insert,
    output logic [2:0]             o_deck_draw,
    output logic [5:0]             o_prev_card,
    input  logic                   i_deck_done,
    input  logic                   i_deck_drawn,
    input  logic [5:0]             i_deck_card
);

    localparam int WDOG_W     = $clog2(WDOG_MAX + 1);
    localparam int DEAL_TOTAL = DEAL_COUNT * N_PLAYERS;
    localparam int DEAL_W     = $clog2(DEAL_TOTAL + 1);

    typedef enum logic [2:0] {
        IDLE, SHUF, SHUF_WAIT, INS, INS_WAIT, ISSUE, COLLECT, FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_shuf_pend;
    logic                r_deal_pend;
    logic                r_deal_active;
    logic [DEAL_W-1:0]   r_deal_left;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_target;
    logic [2:0]          r_num;
    logic [2:0]          r_remain;
    logic                r_is_draw;
    logic [5:0]          r_prev_card;
    logic                r_seen_low;
    logic [WDOG_W-1:0]   r_wdog;
    logic                r_error;
    logic                r_card_valid;
    logic [5:0]          r_card;
    logic [1:0]          r_card_player;

    logic [2:0]          w_num_fix [N_PLAYERS];
    logic                w_win_found;
    logic [1:0]          w_win_idx;
    logic [2:0]          w_win_num;
    logic                w_start_shuf;
    logic                w_start_ins;
    logic                w_start_deal;
    logic                w_start_draw;
    logic                w_watched;
    logic                w_progress;
    logic                w_wd_trip;
    logic                w_fin_done;
    logic                w_got_card;

    // Anything other than a clean 2- or 4-card one-hot request is a single-card draw
    generate
        for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_num
            assign w_num_fix[gi] = (i_req_num[3*gi +: 3] == 3'b010 ||
                                    i_req_num[3*gi +: 3] == 3'b100) ?
                                   i_req_num[3*gi +: 3] : 3'b001;
        end
    endgenerate

    // Round-robin search starting one past the last winner
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = 2'd0;
        w_win_num   = 3'b001;
        for (int k = 1; k <= N_PLAYERS; k++) begin
            if (!w_win_found && i_req[(int'(r_rr_ptr) + k) % N_PLAYERS]) begin
                w_win_found = 1'b1;
                w_win_idx   = 2'((int'(r_rr_ptr) + k) % N_PLAYERS);
                w_win_num   = w_num_fix[(int'(r_rr_ptr) + k) % N_PLAYERS];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection, watchdog trip and Moore-decoded command outputs
    always_comb begin
        w_next_state = r_state;
        w_start_shuf = 1'b0;
        w_start_ins  = 1'b0;
        w_start_deal = 1'b0;
        w_start_draw = 1'b0;
        w_wd_trip    = 1'b0;
        w_got_card   = (r_state == COLLECT) && i_deck_drawn;
        w_fin_done   = (r_state == FINISH) && i_deck_done;
        w_watched    = (r_state == SHUF_WAIT) || (r_state == INS_WAIT) ||
                       (r_state == COLLECT)   || (r_state == FINISH);

        case (r_state)
            IDLE: begin
                // Nothing is issued until the deck reports itself idle
                if (i_deck_done) begin
                    if (r_shuf_pend) begin
                        w_start_shuf = 1'b1;
                        w_next_state = SHUF;
                    end else if (i_discard_valid) begin
                        w_start_ins  = 1'b1;
                        w_next_state = INS;
                    end else if (r_deal_active || r_deal_pend) begin
                        w_start_deal = 1'b1;
                        w_next_state = ISSUE;
                    end else if (w_win_found) begin
                        w_start_draw = 1'b1;
                        w_next_state = ISSUE;
                    end
                end
            end
            SHUF:      w_next_state = SHUF_WAIT;
            SHUF_WAIT: if (i_deck_done && r_seen_low) w_next_state = IDLE;
            INS:       w_next_state = INS_WAIT;
            INS_WAIT:  if (i_deck_done && r_seen_low) w_next_state = IDLE;
            ISSUE:     w_next_state = COLLECT;
            COLLECT:   if (w_got_card && r_remain == 3'd1) w_next_state = FINISH;
            FINISH:    if (i_deck_done) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase

        // Progress means leaving the state or receiving a card
        w_progress = (w_next_state != r_state) || w_got_card;
        if (w_watched && !w_progress && r_wdog == WDOG_W'(WDOG_MAX)) begin
            w_wd_trip    = 1'b1;
            w_next_state = IDLE;
        end

        o_busy        = (r_state != IDLE);
        o_deck_start  = (r_state == SHUF);
        o_deck_insert = (r_state == INS);
        o_discard_ack = (r_state == INS);
        o_prev_card   = (r_state == INS) ? r_prev_card : 6'd0;
        o_deck_draw   = (r_state == ISSUE) ? r_num : 3'd0;
        o_grant       = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            o_grant[p] = (r_state == ISSUE) && r_is_draw && (r_target == 2'(p));
        end
    end

    // Operation bookkeeping: pending flags, deal progress, draw counters, watchdog
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shuf_pend   <= 1'b0;
            r_deal_pend   <= 1'b0;
            r_deal_active <= 1'b0;
            r_deal_left   <= '0;
            r_rr_ptr      <= 2'(N_PLAYERS - 1);
            r_target      <= 2'd0;
            r_num         <= 3'd0;
            r_remain      <= 3'd0;
            r_is_draw     <= 1'b0;
            r_prev_card   <= 6'd0;
            r_seen_low    <= 1'b0;
            r_wdog        <= '0;
            r_error       <= 1'b0;
            r_card_valid  <= 1'b0;
            r_card        <= 6'd0;
            r_card_player <= 2'd0;
        end else begin
            r_card_valid <= 1'b0;

            // A new request pulse wins over the clear of the one being started
            if (w_start_shuf) r_shuf_pend <= 1'b0;
            if (i_shuffle)    r_shuf_pend <= 1'b1;
            if (w_start_deal && !r_deal_active) r_deal_pend <= 1'b0;
            if (i_deal)       r_deal_pend <= 1'b1;

            if (w_start_ins) r_prev_card <= i_discard_card;

            if (w_start_deal) begin
                r_is_draw <= 1'b0;
                r_num     <= 3'b001;
                if (!r_deal_active) begin
                    r_deal_active <= 1'b1;
                    r_deal_left   <= DEAL_W'(DEAL_TOTAL);
                    r_target      <= 2'd0;
                end
            end

            if (w_start_draw) begin
                r_is_draw <= 1'b1;
                r_num     <= w_win_num;
                r_target  <= w_win_idx;
                r_rr_ptr  <= w_win_idx;
            end

            if (r_state == ISSUE) begin
                case (r_num)
                    3'b010:  r_remain <= 3'd2;
                    3'b100:  r_remain <= 3'd4;
                    default: r_remain <= 3'd1;
                endcase
                if (!r_is_draw) r_deal_left <= r_deal_left - DEAL_W'(1);
            end

            if (w_got_card) begin
                r_card_valid  <= 1'b1;
                r_card        <= i_deck_card;
                r_card_player <= r_target;
                r_remain      <= r_remain - 3'd1;
            end

            // Each dealt card goes to the next player in turn
            if (w_fin_done && r_deal_active) begin
                if (r_deal_left == '0) begin
                    r_deal_active <= 1'b0;
                end else begin
                    r_target <= (r_target == 2'(N_PLAYERS - 1)) ? 2'd0 : r_target + 2'd1;
                end
            end

            // Wait states need to see the deck go busy before accepting done
            if (w_next_state != r_state) begin
                r_seen_low <= 1'b0;
            end else if (!i_deck_done) begin
                r_seen_low <= 1'b1;
            end

            if (w_progress) begin
                r_wdog <= '0;
            end else if (w_watched) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end

            if (w_wd_trip) begin
                r_error       <= 1'b1;
                r_deal_active <= 1'b0;
            end
        end
    end

    assign o_card_valid  = r_card_valid;
    assign o_card        = r_card;
    assign o_card_player = r_card_player;
    assign o_error       = r_error;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: behavioural deck responder, card scoreboard,
// table-driven arbitration vectors, hand sequences and randomized draws.
`timescale 1ns/1ps
module tb_draw_scheduler;

    localparam int NP = 4;
    localparam int DC = 7;
    localparam int WD = 255;

    logic            clk = 1'b0;
    logic            rst, shuffle, deal, disc_v;
    logic [NP-1:0]   req;
    logic [3*NP-1:0] req_num;
    logic [5:0]      disc_card;
    logic            ack, card_v, busy, err, dstart, dins;
    logic [NP-1:0]   grant;
    logic [5:0]      card, prev;
    logic [1:0]      card_pl;
    logic [2:0]      ddraw;
    logic            deck_done, deck_drawn_m, man_drawn, deck_drawn;
    logic [5:0]      deck_card_m, man_card, deck_card;

    int n_tests = 0;
    int n_fail  = 0;

    // Deck model state and scoreboard
    int         d_pend = 0, d_gap = 0, d_busy = 0, d_stall = -1;
    bit         d_abort = 1'b1;
    logic [5:0] popped[$];
    int         exp_pl[$];
    int         cards_rcv = 0;
    int         m_rr;

    always #5 clk = ~clk;

    assign deck_drawn = deck_drawn_m | man_drawn;
    assign deck_card  = man_drawn ? man_card : deck_card_m;

    draw_scheduler #(.N_PLAYERS(NP), .DEAL_COUNT(DC), .WDOG_MAX(WD)) dut (
        .i_clk(clk), .i_rst(rst), .i_shuffle(shuffle), .i_deal(deal),
        .i_req(req), .i_req_num(req_num),
        .i_discard_valid(disc_v), .i_discard_card(disc_card),
        .o_discard_ack(ack), .o_grant(grant),
        .o_card_valid(card_v), .o_card(card), .o_card_player(card_pl),
        .o_busy(busy), .o_error(err),
        .o_deck_start(dstart), .o_deck_insert(dins), .o_deck_draw(ddraw), .o_prev_card(prev),
        .i_deck_done(deck_done), .i_deck_drawn(deck_drawn), .i_deck_card(deck_card)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, required event did not occur", nm);
    endtask

    function automatic int n_of(input logic [2:0] num);
        if (num == 3'b010) return 2;
        if (num == 3'b100) return 4;
        return 1;
    endfunction

    function automatic logic [2:0] draw_of(input int n);
        if (n == 4) return 3'b100;
        if (n == 2) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int idx_of(input logic [NP-1:0] g);
        for (int p = 0; p < NP; p++) if (g[p]) return p;
        return 0;
    endfunction

    // Next winner: first requester in the rotation that starts after the last winner
    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        int order[$];
        for (int i = 1; i <= NP; i++) order.push_back((last + i) % NP);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    // Behavioural deck: goes busy on each command, pops the requested cards with gaps
    initial begin
        deck_done = 1'b1; deck_drawn_m = 1'b0; deck_card_m = 6'd0;
        forever begin
            @(negedge clk);
            deck_drawn_m = 1'b0;
            if (d_abort) begin
                d_pend = 0; d_busy = 0; deck_done = 1'b1;
            end else if (dstart || dins) begin
                deck_done = 1'b0; d_busy = $urandom_range(1, 3);
            end else if (ddraw != 3'd0) begin
                deck_done = 1'b0;
                d_pend = (ddraw == 3'b100) ? 4 : (ddraw == 3'b010) ? 2 : 1;
                d_gap = $urandom_range(0, 2);
            end else if (d_pend > 0) begin
                if (d_stall == 0) begin
                    deck_done = 1'b0;
                end else if (d_gap > 0) begin
                    d_gap--;
                end else begin
                    deck_drawn_m = 1'b1;
                    deck_card_m = 6'($urandom);
                    popped.push_back(deck_card_m);
                    d_pend--;
                    if (d_stall > 0) d_stall--;
                    d_gap = $urandom_range(0, 2);
                end
            end else if (d_busy > 0) begin
                d_busy--;
            end else begin
                deck_done = 1'b1;
            end
        end
    end

    // Scoreboard: every delivered card must match the deck's pop order and expected player
    initial begin
        forever begin
            @(negedge clk);
            if (card_v) begin
                if (popped.size() == 0 || exp_pl.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL spurious_card: got card %0h player %0d, required no card", card, card_pl);
                end else begin
                    chk("card_value", card, popped.pop_front());
                    chk("card_player", card_pl, exp_pl.pop_front());
                end
                cards_rcv++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic do_reset();
        d_abort = 1'b1; rst = 1'b1; req = '0; req_num = '0; shuffle = 1'b0; deal = 1'b0;
        disc_v = 1'b0; disc_card = 6'd0; man_drawn = 1'b0; man_card = 6'd0; d_stall = -1;
        repeat (3) @(negedge clk);
        popped.delete(); exp_pl.delete(); cards_rcv = 0; m_rr = NP - 1;
        rst = 1'b0; d_abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_grant(input string nm, output logic [NP-1:0] g);
        g = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                g = grant;
                return;
            end
        end
        fail_now(nm);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy && exp_pl.size() == 0 && deck_done) return;
        end
        fail_now(nm);
    endtask

    task automatic push_pl(input int p, input int n);
        for (int i = 0; i < n; i++) exp_pl.push_back(p);
    endtask

    typedef struct {
        logic [NP-1:0]   req;
        logic [3*NP-1:0] num;
        logic [NP-1:0]   exp_grant;
        logic [2:0]      exp_draw;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [NP-1:0] g;
        int starts, others, busy_after, cnt, cyc, total;
        logic seen;

        rst = 1'b1; req = '0; req_num = '0; shuffle = 1'b0; deal = 1'b0;
        disc_v = 1'b0; disc_card = 6'd0; man_drawn = 1'b0; man_card = 6'd0;

        vt[0] = '{4'b0101, {3'b000, 3'b010, 3'b000, 3'b010}, 4'b0001, 3'b010};
        vt[1] = '{4'b1000, {3'b100, 3'b000, 3'b000, 3'b000}, 4'b1000, 3'b100};
        vt[2] = '{4'b0110, {3'b000, 3'b000, 3'b011, 3'b000}, 4'b0010, 3'b001};
        vt[3] = '{4'b0100, {3'b000, 3'b000, 3'b000, 3'b000}, 4'b0100, 3'b001};
        vt[4] = '{4'b1100, {3'b010, 3'b100, 3'b000, 3'b000}, 4'b0100, 3'b100};
        vt[5] = '{4'b0001, {3'b000, 3'b000, 3'b000, 3'b111}, 4'b0001, 3'b001};
        vt[6] = '{4'b1010, {3'b100, 3'b000, 3'b110, 3'b000}, 4'b0010, 3'b001};

        // Reset state
        do_reset();
        chk("reset_outputs", {ack, grant, card_v, card, card_pl, busy, err, dstart, dins, ddraw, prev}, 0);

        // Table vectors: first grant after reset
        foreach (vt[i]) begin
            do_reset();
            req = vt[i].req; req_num = vt[i].num;
            wait_grant("table_grant_wait", g);
            chk("table_grant", g, vt[i].exp_grant);
            chk("table_draw", ddraw, vt[i].exp_draw);
            chk("table_busy", busy, 1);
            push_pl(idx_of(vt[i].exp_grant), n_of(vt[i].exp_draw));
            req = '0;
            wait_idle("table_idle");
        end

        // Shuffle: one start pulse, busy until the deck finishes, no other commands
        do_reset();
        shuffle = 1'b1; @(negedge clk); shuffle = 1'b0;
        starts = 0; others = 0; busy_after = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dstart) starts++;
            if (dins || ddraw != 0 || grant != 0 || ack || prev != 0) others++;
            if (starts == 1 && !dstart && busy) busy_after++;
        end
        chk("shuf_start_count", starts, 1);
        chk("shuf_other_cmds", others, 0);
        chk("shuf_busy_wait", busy_after >= 2, 1);
        chk("shuf_busy_end", busy, 0);

        // Two 2-card requests served in round-robin order
        do_reset();
        req = 4'b0101; req_num = {3'b000, 3'b010, 3'b000, 3'b010};
        wait_grant("rr_first_wait", g);
        chk("rr_first_grant", g, 4'b0001);
        chk("rr_first_draw", ddraw, 3'b010);
        push_pl(0, 2);
        req = 4'b0100;
        wait_grant("rr_second_wait", g);
        chk("rr_second_grant", g, 4'b0100);
        chk("rr_second_draw", ddraw, 3'b010);
        push_pl(2, 2);
        req = '0;
        wait_idle("rr_idle");
        chk("rr_cards", cards_rcv, 4);

        // Discard has priority over a simultaneous draw
        do_reset();
        disc_v = 1'b1; disc_card = 6'h1C; req = 4'b0001; req_num = '0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (dins || ack || grant != 0) begin
                seen = 1'b1;
                chk("disc_insert", dins, 1);
                chk("disc_ack", ack, 1);
                chk("disc_prev", prev, 6'h1C);
                chk("disc_no_grant", grant, 0);
            end
        end
        if (!seen) fail_now("disc_first_cmd");
        disc_v = 1'b0;
        wait_grant("disc_grant_wait", g);
        chk("disc_grant_after", g, 4'b0001);
        chk("disc_draw", ddraw, 3'b001);
        push_pl(0, 1);
        req = '0;
        wait_idle("disc_idle");

        // Discard raised mid-draw is held off until the draw finishes
        req = 4'b0010; req_num = {3'b000, 3'b000, 3'b100, 3'b000};
        wait_grant("hold_grant_wait", g);
        chk("hold_grant", g, 4'b0010);
        push_pl(1, 4);
        req = '0; disc_v = 1'b1; disc_card = 6'h2A;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (ack) begin
                seen = 1'b1;
                chk("hold_cards_done", exp_pl.size(), 0);
                chk("hold_prev", prev, 6'h2A);
            end
        end
        if (!seen) fail_now("hold_ack");
        disc_v = 1'b0;
        wait_idle("hold_idle");

        // Deal: 28 single cards to players 0,1,2,3 in turn, requests ignored, no grants
        do_reset();
        deal = 1'b1; @(negedge clk); deal = 1'b0;
        req = 4'b1111; req_num = '0;
        for (int r = 0; r < DC; r++) for (int p = 0; p < NP; p++) exp_pl.push_back(p);
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (grant != 0) cnt++;
            if (cards_rcv >= DC * NP) seen = 1'b1;
        end
        req = '0;
        if (!seen) fail_now("deal_cards");
        chk("deal_no_grant", cnt, 0);
        chk("deal_card_count", cards_rcv, DC * NP);
        wait_idle("deal_idle");
        req = 4'b0010;
        wait_grant("post_deal_wait", g);
        chk("post_deal_grant", g, 4'b0010);
        push_pl(1, 1);
        req = '0;
        wait_idle("post_deal_idle");

        // Watchdog: deck stalls after 2 of 4 cards
        do_reset();
        d_stall = 2;
        req = 4'b0001; req_num = {9'd0, 3'b100};
        wait_grant("wd_grant_wait", g);
        chk("wd_draw", ddraw, 3'b100);
        push_pl(0, 4);
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cards_rcv == 2) seen = 1'b1;
        end
        if (!seen) fail_now("wd_two_cards");
        cyc = 0; seen = 1'b0;
        for (int i = 0; i < WD + 50 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (err) seen = 1'b1;
        end
        if (!seen) fail_now("wd_error");
        chk("wd_delay_in_range", (cyc >= WD - 1) && (cyc <= WD + 2), 1);
        chk("wd_busy_low", busy, 0);
        repeat (5) @(negedge clk);
        chk("wd_error_sticky", err, 1);
        chk("wd_cards", cards_rcv, 2);
        do_reset();
        chk("wd_error_cleared", err, 0);

        // Reset in the middle of a 4-card collect
        d_stall = 1;
        req = 4'b0001; req_num = {9'd0, 3'b100};
        wait_grant("rst_grant_wait", g);
        push_pl(0, 4);
        req = '0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cards_rcv == 1) seen = 1'b1;
        end
        if (!seen) fail_now("rst_one_card");
        rst = 1'b1; d_abort = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {ack, grant, card_v, card, card_pl, busy, err, dstart, dins, ddraw, prev}, 0);
        rst = 1'b0; d_abort = 1'b0; d_stall = -1;
        popped.delete(); exp_pl.delete();
        @(negedge clk);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            man_card = 6'(k + 5); man_drawn = 1'b1;
            @(negedge clk);
            if (card_v) cnt++;
            man_drawn = 1'b0;
            @(negedge clk);
            if (card_v) cnt++;
        end
        chk("rst_extra_drawn_ignored", cnt, 0);
        chk("rst_busy_low", busy, 0);

        // Randomized draws against the round-robin reference model
        do_reset();
        total = 0;
        for (int it = 0; it < 60; it++) begin
            int w, n;
            logic [NP-1:0] nw;
            nw = NP'($urandom_range(0, 15));
            for (int p = 0; p < NP; p++) begin
                if (nw[p] && !req[p]) begin
                    req[p] = 1'b1;
                    req_num[3*p +: 3] = 3'($urandom);
                end
            end
            if (req == '0) begin
                req[0] = 1'b1; req_num[2:0] = 3'($urandom);
            end
            w = rr_pick(req, m_rr);
            n = n_of(req_num[3*w +: 3]);
            wait_grant("rand_grant_wait", g);
            chk("rand_grant", g, NP'(1) << w);
            chk("rand_draw", ddraw, draw_of(n));
            push_pl(w, n);
            total += n;
            req[w] = 1'b0;
            m_rr = w;
        end
        req = '0;
        wait_idle("rand_idle");
        chk("rand_card_total", cards_rcv, total);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
